// File: rtl/lift_call_panel.sv
// ============================================================================
// Module   : lift_call_panel
// Purpose  : Lift call panel. It registers button presses as lamps and issues
//            pending calls by round-robin, with re-issue on timeout and halt.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lift_call_panel #(
    parameter int ISSUE_GAP    = 2,
    parameter int RETRY_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] buttons,
    input  logic       emergency_stop,
    input  logic [2:0] current_floor,
    input  logic [1:0] door,
    output logic [2:0] req_floor,
    output logic       req_valid,
    output logic [7:0] lamps,
    output logic [3:0] pending_count,
    output logic       halted
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    // The IDLE re-arm cycle is one of the idle cycles, so GAP runs one short.
    localparam int         c_GAP_CYCLES = (ISSUE_GAP >= 2) ? ISSUE_GAP - 1 : 0;
    localparam logic [3:0] c_GAP_LAST   = 4'((c_GAP_CYCLES > 0) ? c_GAP_CYCLES - 1 : 0);
    localparam logic [7:0] c_RETRY_LAST = 8'(RETRY_CYCLES - 1);

    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic [7:0] r_sync3;
    logic [7:0] r_lamps;
    logic [7:0] r_issued;
    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [3:0] r_gap_cnt;
    logic [2:0] r_last;
    logic [2:0] r_req_floor;
    logic [7:0] r_retry;
    logic [3:0] r_pending;

    logic       w_door_open;
    logic [7:0] w_svc_mask;
    logic [7:0] w_rise;
    logic [7:0] w_lamps_nxt;
    logic       w_service;
    logic [7:0] w_eligible;
    logic [2:0] w_sel;
    logic [2:0] w_idx;
    logic       w_found;
    logic       w_fire;
    logic       w_retry_hit;
    logic       w_halt_exit;
    logic [7:0] w_issued_nxt;
    logic [3:0] w_pop;

    assign w_door_open = (door == 2'b10);
    assign w_svc_mask  = w_door_open ? (8'b1 << current_floor) : 8'h00;
    assign w_rise      = r_sync2 & ~r_sync3;
    assign w_lamps_nxt = (r_lamps | w_rise) & ~w_svc_mask;
    assign w_service   = |(r_lamps & w_svc_mask);
    // A floor being served this cycle is never offered for issue.
    assign w_eligible  = r_lamps & ~r_issued & ~w_svc_mask;

    always_comb begin
        w_sel   = 3'd0;
        w_found = 1'b0;
        w_idx   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            w_idx = r_last + 3'(i + 1);
            if (!w_found && w_eligible[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_fire      = (r_state == S_ISSUE) && !emergency_stop && w_found;
    assign w_halt_exit = (r_state == S_HALT) && !emergency_stop;
    assign w_retry_hit = !w_fire && !w_service && (r_state != S_HALT)
                         && (r_lamps != 8'h00) && (r_retry == c_RETRY_LAST);

    always_comb begin
        w_issued_nxt = r_issued;
        if (w_fire) begin
            w_issued_nxt = w_issued_nxt | (8'b1 << w_sel);
        end
        w_issued_nxt = w_issued_nxt & ~w_svc_mask;
        if (w_retry_hit || w_halt_exit) begin
            w_issued_nxt = 8'h00;
        end
    end

    always_comb begin
        w_pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_pop = w_pop + {3'd0, r_lamps[i]};
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (emergency_stop) begin
            w_state_nxt = S_HALT;
        end else begin
            case (r_state)
                S_IDLE:  if (|w_eligible) w_state_nxt = S_ISSUE;
                S_ISSUE: w_state_nxt = (c_GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                S_GAP:   if (r_gap_cnt == c_GAP_LAST) w_state_nxt = S_IDLE;
                S_HALT:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        req_valid     = w_fire;
        req_floor     = w_fire ? w_sel : r_req_floor;
        halted        = (r_state == S_HALT);
        lamps         = r_lamps;
        pending_count = r_pending;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1     <= 8'h00;
            r_sync2     <= 8'h00;
            r_sync3     <= 8'h00;
            r_lamps     <= 8'h00;
            r_issued    <= 8'h00;
            r_gap_cnt   <= 4'd0;
            r_last      <= 3'd7;
            r_req_floor <= 3'd0;
            r_retry     <= 8'd0;
            r_pending   <= 4'd0;
        end else begin
            r_sync1   <= buttons;
            r_sync2   <= r_sync1;
            r_sync3   <= r_sync2;
            r_lamps   <= w_lamps_nxt;
            r_issued  <= w_issued_nxt;
            r_pending <= w_pop;

            if (r_state == S_GAP) begin
                r_gap_cnt <= r_gap_cnt + 4'd1;
            end else begin
                r_gap_cnt <= 4'd0;
            end

            if (w_fire) begin
                r_last      <= w_sel;
                r_req_floor <= w_sel;
            end

            if (w_fire || w_service || w_retry_hit) begin
                r_retry <= 8'd0;
            end else if ((r_state != S_HALT) && (r_lamps != 8'h00)
                         && (r_retry != c_RETRY_LAST)) begin
                r_retry <= r_retry + 8'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/lift_call_panel.md
LIFT_CALL_PANEL -- requirements
Module: lift_call_panel

Interface
REQ-001 The block SHALL have parameter ISSUE_GAP, default 2, giving the idle cycles between consecutive issued requests (range 0..15).
REQ-002 The block SHALL have parameter RETRY_CYCLES, default 64, giving the cycles without service after which all pending calls are re-issued (range 2..255).
REQ-003 The block SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have input reset, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have input buttons, 8 bits: asynchronous call buttons, bit n = floor n, level-high while pressed.
REQ-006 The block SHALL have input emergency_stop, 1 bit: synchronous level; while high, no requests issue.
REQ-007 The block SHALL have input current_floor, 3 bits: floor the car currently occupies.
REQ-008 The block SHALL have input door, 2 bits: door status; 2'b10 = open, any other value = not open.
REQ-009 The block SHALL have output req_floor, 3 bits: floor number of the issued call.
REQ-010 The block SHALL have output req_valid, 1 bit: one-cycle pulse qualifying req_floor.
REQ-011 The block SHALL have output lamps, 8 bits: call-registered lamp per floor.
REQ-012 The block SHALL have output pending_count, 4 bits: population count of lamps (0..8).
REQ-013 The block SHALL have output halted, 1 bit: high while in state HALT.

Function
REQ-014 Each buttons bit SHALL pass through a 2-flop synchronizer; a call registers on the synchronized rising edge only (held buttons register once).
REQ-015 A registered call SHALL set lamps[n] unless door==2'b10 and current_floor==n in that cycle, in which case it is discarded.
REQ-016 Service SHALL occur when door==2'b10: lamps[current_floor] and issued[current_floor] clear that cycle; clear wins over a same-cycle set for that floor.
REQ-017 An internal issued[7:0] mask SHALL mark calls already sent; a floor is eligible when lamps[n]=1 and issued[n]=0.
REQ-018 FSM states: IDLE, ISSUE, GAP, HALT.
REQ-019 IDLE -> ISSUE when any floor is eligible and emergency_stop=0.
REQ-020 ISSUE (one cycle): select the eligible floor by round-robin, searching upward (mod 8) from last_issued+1; drive req_floor, pulse req_valid, set issued bit, update last_issued; then -> GAP, or -> IDLE if ISSUE_GAP=0.
REQ-021 GAP SHALL count ISSUE_GAP cycles, then -> IDLE; req_valid=0 throughout.
REQ-022 req_floor SHALL hold its last issued value between pulses.
REQ-023 A retry counter (8 bits) SHALL reset to 0 on every req_valid or service event, increment each cycle while lamps!=0, saturate at RETRY_CYCLES; on reaching RETRY_CYCLES it clears issued[7:0] and reloads to 0.
REQ-024 Any state -> HALT when emergency_stop=1, taking priority over all other transitions; an in-progress ISSUE cycle is suppressed (no pulse).
REQ-025 In HALT: lamps, issued, synchronizer and registration continue; retry counter held; req_valid=0; halted=1.
REQ-026 HALT -> IDLE on the first cycle emergency_stop=0, with issued[7:0] cleared so all pending calls are re-issued.
REQ-027 pending_count SHALL be registered, equal to popcount(lamps) one cycle after lamps changes.
REQ-028 At most one req_valid pulse SHALL occur per ISSUE_GAP+1 cycles.

Reset
REQ-029 While reset=1 (asynchronous): state=IDLE, lamps=0, issued=0, req_floor=0, req_valid=0, pending_count=0, halted=0, last_issued=7, retry counter=0, synchronizers=0.
REQ-030 Reset asserted mid-issue SHALL drop req_valid immediately and discard all pending calls; the first issue after release searches from floor 0.

Verification
REQ-031 Reset release, press buttons[5] for 3 cycles -> lamps=8'h20 after 3 cycles, one req_valid with req_floor=5, pending_count=1.
REQ-032 Press floors 2,6,1 simultaneously, ISSUE_GAP=2 -> pulses in order 1,2,6 spaced exactly 3 cycles apart.
REQ-033 Lamp 3 pending; drive current_floor=3, door=2'b10 -> lamps[3]=0 next cycle; press button 3 while door open there -> no lamp, no pulse.
REQ-034 Lamp 4 issued, never served, RETRY_CYCLES=64 -> second req_valid with req_floor=4 exactly 64 cycles after the first + FSM latency (≤2 cycles).
REQ-035 emergency_stop=1 with floors 0,7 pending -> halted=1, no pulses, new press of floor 3 lights lamp; release -> pulses re-issue all of 0,3,7 in round-robin order.
REQ-036 Assert reset in the ISSUE cycle -> req_valid low the same cycle, lamps=0, pending_count=0.
